mealy_decoder: RTL

Receive-side inverse of the 4-state Mealy transducer. The block consumes the 2-bit symbol stream `y` that the transducer produces and replays the transducer's state machine to recover the original serial input bit `x`. It assembles the recovered bits into bytes and flags symbols that the transducer cannot emit from the current state. It sits directly downstream of the transducer output on the same clock.

---
 rtl/mealy_decoder.sv | 55 +++++
 1 files changed

// File: rtl/mealy_decoder.sv
// mealy_decoder: replays the 4-state Mealy transducer to recover serial bits, assemble bytes and flag illegal symbols
module mealy_decoder #(
  parameter logic [1:0] INIT_STATE = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] y_in,
  input  logic       y_valid,
  output logic       x_out,
  output logic       x_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       err,
  output logic [7:0] err_count,
  output logic [1:0] stateReg
);
  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11} state_t;
  state_t st, nxt;
  logic legal, xd;
  logic [2:0] bit_cnt;
  logic [7:0] sr;
  assign stateReg = st;
  always_comb begin
    legal = y_in != 2'b11 && (st == S0 || st == S1 ? y_in != 2'b10 : y_in != 2'b01);
    xd = st == S1 ? y_in == 2'b01 : y_in == 2'b00;
    nxt = st == S0 ? (y_in == 2'b00 ? S2 : S0) :
          st == S1 ? (y_in == 2'b00 ? S0 : S1) :
          st == S2 ? (y_in == 2'b10 ? S1 : S0) : S3;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= state_t'(INIT_STATE);
      x_out <= 1'b0;
      x_valid <= 1'b0;
      byte_out <= 8'h00;
      byte_valid <= 1'b0;
      err <= 1'b0;
      err_count <= 8'h00;
      bit_cnt <= 3'd0;
      sr <= 8'h00;
    end else begin
      x_valid <= y_valid && legal;
      err <= y_valid && !legal;
      byte_valid <= y_valid && legal && bit_cnt == 3'd7;
      if (y_valid && legal) begin
        st <= nxt;
        x_out <= xd;
        sr[bit_cnt] <= xd;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_out <= {xd, sr[6:0]};
      end
      if (y_valid && !legal && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
endmodule
